// File: rtl/ddrphy_odt_lane_ctrl.sv
// ddrphy_odt_lane_ctrl: per-lane ODT pulse word generator and IOD output
// delay-line tap stepper. Every lane is an independent copy of both engines.
//
// Tap stepper states:
//   state  | meaning
//   S_LOAD | dl_load pulse, cur_tap restored to DEF_TAP
//   S_IDLE | waiting for tap_req
//   S_STEP | one dl_move pulse, cur_tap moves one tap toward the target
//   S_GAP  | settle time between moves (STEP_GAP-1 cycles)
//   S_DONE | one-cycle tap_done pulse
module ddrphy_odt_lane_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int GEAR     = 4,
  parameter int TAP_W    = 8,
  parameter int MAX_TAP  = 127,
  parameter int DEF_TAP  = 1,
  parameter int LAT_W    = 4,
  parameter int DUR_W    = 4,
  parameter int STEP_GAP = 4
) (
  input  logic                      FAB_CLK,
  input  logic                      TX_SYNC_RST,
  input  logic [NUM_CH-1:0]         odt_req,
  input  logic [NUM_CH*LAT_W-1:0]   odt_lat,
  input  logic [NUM_CH*DUR_W-1:0]   odt_dur,
  input  logic [NUM_CH*2-1:0]       odt_phase,
  output logic [NUM_CH-1:0]         odt_drop,
  output logic [NUM_CH*GEAR-1:0]    tx_data,
  output logic [NUM_CH*GEAR-1:0]    oe_data,
  output logic [NUM_CH-1:0]         odt_en,
  input  logic [NUM_CH-1:0]         tap_req,
  input  logic [NUM_CH*TAP_W-1:0]   tap_target,
  input  logic [NUM_CH-1:0]         tap_clear,
  input  logic [NUM_CH-1:0]         dl_out_of_range,
  output logic [NUM_CH-1:0]         dl_move,
  output logic [NUM_CH-1:0]         dl_direction,
  output logic [NUM_CH-1:0]         dl_load,
  output logic [NUM_CH*TAP_W-1:0]   cur_tap,
  output logic [NUM_CH-1:0]         tap_busy,
  output logic [NUM_CH-1:0]         tap_done,
  output logic [NUM_CH-1:0]         tap_oor
);

  localparam int GAP_W = (STEP_GAP > 2) ? $clog2(STEP_GAP - 1) : 1;

  localparam logic [GEAR-1:0]  ALL1      = '1;
  localparam logic [LAT_W-1:0] LAT_ZERO  = '0;
  localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
  localparam logic [DUR_W-1:0] DUR_ZERO  = '0;
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
  localparam logic [DUR_W:0]   REM_ZERO  = '0;
  localparam logic [DUR_W:0]   REM_ONE   = (DUR_W+1)'(1);
  localparam logic [TAP_W-1:0] TAP_ZERO  = '0;
  localparam logic [TAP_W-1:0] TAP_ONE   = TAP_W'(1);
  localparam logic [TAP_W-1:0] MAX_TAP_V = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] DEF_TAP_V = TAP_W'(DEF_TAP);
  localparam logic [GAP_W-1:0] GAP_ZERO  = '0;
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(STEP_GAP - 2);

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_IDLE = 3'd1,
    S_STEP = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } tap_state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane

    // ---------------- ODT pulse engine ----------------
    logic [LAT_W-1:0] w_lat;
    logic [DUR_W-1:0] w_dur;
    logic [DUR_W-1:0] w_dur_eff;
    logic [1:0]       w_phase;
    logic [DUR_W:0]   w_first_rem;

    logic             r_odt_en;
    logic             r_pend;
    logic             r_drop;
    logic [LAT_W-1:0] r_wait;
    logic [DUR_W:0]   r_rem;
    logic [1:0]       r_phase;
    logic [GEAR-1:0]  r_tx;
    logic [GEAR-1:0]  r_oe;

    assign w_lat     = odt_lat[i*LAT_W +: LAT_W];
    assign w_dur     = odt_dur[i*DUR_W +: DUR_W];
    assign w_phase   = odt_phase[i*2 +: 2];
    assign w_dur_eff = (w_dur == DUR_ZERO) ? DUR_ONE : w_dur;
    // Words still to follow the first one: d-1 full words, plus a tail word
    // carrying the leftover bits when the pulse starts mid-word.
    assign w_first_rem = (w_phase != 2'd0) ? {1'b0, w_dur_eff}
                                           : ({1'b0, w_dur_eff} - REM_ONE);

    // Accept/drop requests, count down latency, then stream head/body/tail words.
    always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST) begin
        r_odt_en <= 1'b0;
        r_pend   <= 1'b0;
        r_drop   <= 1'b0;
        r_wait   <= LAT_ZERO;
        r_rem    <= REM_ZERO;
        r_phase  <= 2'd0;
        r_tx     <= '0;
        r_oe     <= '1;
      end else begin
        r_oe   <= '1;
        r_drop <= odt_req[i] & r_odt_en;
        if (!r_odt_en) begin
          if (odt_req[i]) begin
            r_odt_en <= 1'b1;
            r_phase  <= w_phase;
            r_rem    <= w_first_rem;
            if (w_lat == LAT_ZERO) begin
              r_pend <= 1'b0;
              r_tx   <= ALL1 << w_phase;
            end else begin
              r_pend <= 1'b1;
              r_wait <= w_lat;
              r_tx   <= '0;
            end
          end
        end else if (r_pend) begin
          if (r_wait == LAT_ONE) begin
            r_pend <= 1'b0;
            r_tx   <= ALL1 << r_phase;
          end else begin
            r_wait <= r_wait - LAT_ONE;
          end
        end else if (r_rem == REM_ZERO) begin
          r_odt_en <= 1'b0;
          r_tx     <= '0;
        end else begin
          r_tx  <= ((r_rem == REM_ONE) && (r_phase != 2'd0)) ? ~(ALL1 << r_phase) : ALL1;
          r_rem <= r_rem - REM_ONE;
        end
      end
    end

    assign odt_en[i]                = r_odt_en;
    assign odt_drop[i]              = r_drop;
    assign tx_data[i*GEAR +: GEAR]  = r_tx;
    assign oe_data[i*GEAR +: GEAR]  = r_oe;

    // ---------------- Tap stepper ----------------
    tap_state_t       r_state, w_nxt_state;
    logic [TAP_W-1:0] r_tap, w_nxt_tap;
    logic [TAP_W-1:0] r_tgt, w_nxt_tgt;
    logic [TAP_W-1:0] w_req_tgt;
    logic [GAP_W-1:0] r_gap, w_nxt_gap;
    logic             w_step;
    logic             w_dir;
    logic             w_oor_set;
    logic             r_move, r_dir, r_load, r_done, r_busy, r_oor;

    assign w_req_tgt = tap_target[i*TAP_W +: TAP_W];

    // Next-state, next tap and move decision; outputs are registered from these.
    always_comb begin
      w_nxt_state = r_state;
      w_nxt_tap   = r_tap;
      w_nxt_tgt   = r_tgt;
      w_nxt_gap   = r_gap;
      w_step      = 1'b0;
      w_dir       = r_dir;
      w_oor_set   = 1'b0;
      case (r_state)
        S_LOAD: begin
          w_nxt_state = S_IDLE;
          w_nxt_tap   = DEF_TAP_V;
        end
        S_IDLE: begin
          if (tap_req[i]) begin
            w_nxt_tgt = w_req_tgt;
            if (w_req_tgt > MAX_TAP_V) begin
              w_oor_set   = 1'b1;
              w_nxt_state = S_DONE;
            end else if (w_req_tgt == r_tap) begin
              w_nxt_state = S_DONE;
            end else begin
              w_nxt_state = S_STEP;
              w_step      = 1'b1;
              w_dir       = (w_req_tgt > r_tap);
            end
          end
        end
        S_STEP: begin
          if (dl_out_of_range[i]) begin
            w_oor_set   = 1'b1;
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_state = S_GAP;
            w_nxt_gap   = GAP_INIT;
          end
        end
        S_GAP: begin
          if (dl_out_of_range[i]) begin
            w_oor_set   = 1'b1;
            w_nxt_state = S_DONE;
          end else if (r_gap != GAP_ZERO) begin
            w_nxt_gap = r_gap - GAP_ONE;
          end else if (r_tap != r_tgt) begin
            w_nxt_state = S_STEP;
            w_step      = 1'b1;
            w_dir       = (r_tgt > r_tap);
          end else begin
            w_nxt_state = S_DONE;
          end
        end
        S_DONE:  w_nxt_state = S_IDLE;
        default: w_nxt_state = S_LOAD;
      endcase
      // Tap tracking is clamped so it can never wrap outside 0..MAX_TAP.
      if (w_step) begin
        if (w_dir && (r_tap < MAX_TAP_V)) begin
          w_nxt_tap = r_tap + TAP_ONE;
        end else if (!w_dir && (r_tap != TAP_ZERO)) begin
          w_nxt_tap = r_tap - TAP_ONE;
        end
      end
    end

    // State register plus registered IOD controls and status flags.
    always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST) begin
        r_state <= S_LOAD;
        r_tap   <= DEF_TAP_V;
        r_tgt   <= DEF_TAP_V;
        r_gap   <= GAP_ZERO;
        r_move  <= 1'b0;
        r_dir   <= 1'b0;
        r_load  <= 1'b1;
        r_done  <= 1'b0;
        r_busy  <= 1'b1;
        r_oor   <= 1'b0;
      end else begin
        r_state <= w_nxt_state;
        r_tap   <= w_nxt_tap;
        r_tgt   <= w_nxt_tgt;
        r_gap   <= w_nxt_gap;
        r_move  <= w_step;
        r_dir   <= w_dir;
        r_load  <= (w_nxt_state == S_LOAD);
        r_done  <= (w_nxt_state == S_DONE);
        r_busy  <= (w_nxt_state != S_IDLE);
        if (w_oor_set) begin
          r_oor <= 1'b1;
        end else if (tap_clear[i]) begin
          r_oor <= 1'b0;
        end
      end
    end

    assign dl_move[i]                = r_move;
    assign dl_direction[i]           = r_dir;
    assign dl_load[i]                = r_load;
    assign tap_done[i]               = r_done;
    assign tap_busy[i]               = r_busy;
    assign tap_oor[i]                = r_oor;
    assign cur_tap[i*TAP_W +: TAP_W] = r_tap;
  end

endmodule

// File: tb/tb_ddrphy_odt_lane_ctrl.sv
// Directed bench for ddrphy_odt_lane_ctrl: ODT word shaping, request drop,
// tap stepping up/down, illegal targets, IOD out-of-range abort and reset.
module tb_ddrphy_odt_lane_ctrl;

  logic        FAB_CLK = 1'b0;
  logic        TX_SYNC_RST;
  logic [1:0]  odt_req;
  logic [7:0]  odt_lat;
  logic [7:0]  odt_dur;
  logic [3:0]  odt_phase;
  logic [1:0]  odt_drop;
  logic [7:0]  tx_data;
  logic [7:0]  oe_data;
  logic [1:0]  odt_en;
  logic [1:0]  tap_req;
  logic [15:0] tap_target;
  logic [1:0]  tap_clear;
  logic [1:0]  dl_out_of_range;
  logic [1:0]  dl_move;
  logic [1:0]  dl_direction;
  logic [1:0]  dl_load;
  logic [15:0] cur_tap;
  logic [1:0]  tap_busy;
  logic [1:0]  tap_done;
  logic [1:0]  tap_oor;

  int n_pass;
  int n_chk;

  ddrphy_odt_lane_ctrl dut (
    .FAB_CLK         (FAB_CLK),
    .TX_SYNC_RST     (TX_SYNC_RST),
    .odt_req         (odt_req),
    .odt_lat         (odt_lat),
    .odt_dur         (odt_dur),
    .odt_phase       (odt_phase),
    .odt_drop        (odt_drop),
    .tx_data         (tx_data),
    .oe_data         (oe_data),
    .odt_en          (odt_en),
    .tap_req         (tap_req),
    .tap_target      (tap_target),
    .tap_clear       (tap_clear),
    .dl_out_of_range (dl_out_of_range),
    .dl_move         (dl_move),
    .dl_direction    (dl_direction),
    .dl_load         (dl_load),
    .cur_tap         (cur_tap),
    .tap_busy        (tap_busy),
    .tap_done        (tap_done),
    .tap_oor         (tap_oor)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic test_reset();
    TX_SYNC_RST = 1'b1;
    tap_req     = 2'b01;
    repeat (3) tick();
    n_chk++; if (tx_data !== 8'h00) $display("FAIL rst_tx got %h exp 00", tx_data); else n_pass++;
    n_chk++; if (oe_data !== 8'hFF) $display("FAIL rst_oe got %h exp ff", oe_data); else n_pass++;
    n_chk++; if (odt_en !== 2'b00) $display("FAIL rst_odt_en got %b exp 00", odt_en); else n_pass++;
    n_chk++; if (odt_drop !== 2'b00) $display("FAIL rst_drop got %b exp 00", odt_drop); else n_pass++;
    n_chk++; if (dl_move !== 2'b00) $display("FAIL rst_move got %b exp 00", dl_move); else n_pass++;
    n_chk++; if (dl_direction !== 2'b00) $display("FAIL rst_dir got %b exp 00", dl_direction); else n_pass++;
    n_chk++; if (tap_done !== 2'b00) $display("FAIL rst_done got %b exp 00", tap_done); else n_pass++;
    n_chk++; if (tap_oor !== 2'b00) $display("FAIL rst_oor got %b exp 00", tap_oor); else n_pass++;
    n_chk++; if (cur_tap !== 16'h0101) $display("FAIL rst_cur_tap got %h exp 0101", cur_tap); else n_pass++;
    tick();
    TX_SYNC_RST = 1'b0;
    n_chk++; if (dl_load !== 2'b11) $display("FAIL load_c1 got %b exp 11", dl_load); else n_pass++;
    n_chk++; if (tap_busy !== 2'b11) $display("FAIL busy_c1 got %b exp 11", tap_busy); else n_pass++;
    tick();
    tap_req = 2'b00;
    n_chk++; if (dl_load !== 2'b00) $display("FAIL load_c2 got %b exp 00", dl_load); else n_pass++;
    n_chk++; if (tap_busy !== 2'b00) $display("FAIL busy_c2 got %b exp 00", tap_busy); else n_pass++;
    tick();
    n_chk++; if (tap_busy !== 2'b00) $display("FAIL busy_c3 got %b exp 00", tap_busy); else n_pass++;
    n_chk++; if (dl_move !== 2'b00) $display("FAIL move_c3 got %b exp 00", dl_move); else n_pass++;
    n_chk++; if (cur_tap[7:0] !== 8'd1) $display("FAIL cur_tap_c3 got %0d exp 1", cur_tap[7:0]); else n_pass++;
  endtask

  // Lane 0: lat=2, dur=3, phase=0 -> full words at T+3..T+5, odt_en T+1..T+5.
  task automatic test_odt_basic();
    logic [3:0] exp_tx;
    logic       exp_en;
    odt_req = 2'b01; odt_lat[3:0] = 4'd2; odt_dur[3:0] = 4'd3; odt_phase[1:0] = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) odt_req = 2'b00;
      exp_tx = (k >= 3 && k <= 5) ? 4'b1111 : 4'b0000;
      exp_en = (k <= 5);
      n_chk++; if (tx_data[3:0] !== exp_tx) $display("FAIL basic_tx k=%0d got %b exp %b", k, tx_data[3:0], exp_tx); else n_pass++;
      n_chk++; if (odt_en[0] !== exp_en) $display("FAIL basic_en k=%0d got %b exp %b", k, odt_en[0], exp_en); else n_pass++;
      n_chk++; if (tx_data[7:4] !== 4'b0000) $display("FAIL basic_lane1_tx k=%0d got %b exp 0000", k, tx_data[7:4]); else n_pass++;
      n_chk++; if (oe_data !== 8'hFF) $display("FAIL basic_oe k=%0d got %h exp ff", k, oe_data); else n_pass++;
    end
  endtask

  // Lane 1: lat=0, dur=2, phase=1 -> 1110,1111,0001; a second request is dropped.
  task automatic test_odt_phase();
    logic [3:0] exp_tx;
    logic       exp_en;
    logic       exp_drop;
    int         nbits;
    nbits = 0;
    odt_req = 2'b10; odt_lat[7:4] = 4'd0; odt_dur[7:4] = 4'd2; odt_phase[3:2] = 2'd1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      odt_req = 2'b00;
      case (k)
        1:       exp_tx = 4'b1110;
        2:       exp_tx = 4'b1111;
        3:       exp_tx = 4'b0001;
        default: exp_tx = 4'b0000;
      endcase
      exp_en   = (k <= 3);
      exp_drop = (k == 3);
      nbits += $countones(tx_data[7:4]);
      n_chk++; if (tx_data[7:4] !== exp_tx) $display("FAIL phase_tx k=%0d got %b exp %b", k, tx_data[7:4], exp_tx); else n_pass++;
      n_chk++; if (odt_en[1] !== exp_en) $display("FAIL phase_en k=%0d got %b exp %b", k, odt_en[1], exp_en); else n_pass++;
      n_chk++; if (odt_drop[1] !== exp_drop) $display("FAIL phase_drop k=%0d got %b exp %b", k, odt_drop[1], exp_drop); else n_pass++;
      if (k == 2) begin
        odt_req = 2'b10; odt_lat[7:4] = 4'd0; odt_dur[7:4] = 4'd5; odt_phase[3:2] = 2'd3;
      end
    end
    n_chk++; if (nbits !== 8) $display("FAIL phase_bits got %0d exp 8", nbits); else n_pass++;
  endtask

  // Lane 0: lat=1, dur=0 (treated as 1), phase=2 -> 1100 then 0011.
  task automatic test_odt_dur0();
    logic [3:0] exp_tx;
    logic       exp_en;
    odt_req = 2'b01; odt_lat[3:0] = 4'd1; odt_dur[3:0] = 4'd0; odt_phase[1:0] = 2'd2;
    for (int k = 1; k <= 5; k++) begin
      tick();
      odt_req = 2'b00;
      case (k)
        2:       exp_tx = 4'b1100;
        3:       exp_tx = 4'b0011;
        default: exp_tx = 4'b0000;
      endcase
      exp_en = (k <= 3);
      n_chk++; if (tx_data[3:0] !== exp_tx) $display("FAIL dur0_tx k=%0d got %b exp %b", k, tx_data[3:0], exp_tx); else n_pass++;
      n_chk++; if (odt_en[0] !== exp_en) $display("FAIL dur0_en k=%0d got %b exp %b", k, odt_en[0], exp_en); else n_pass++;
    end
  endtask

  // Lane 0: one-word pulses; a request the cycle odt_en is low is accepted.
  task automatic test_back_to_back();
    logic [3:0] exp_tx;
    logic       exp_en;
    odt_req = 2'b01; odt_lat[3:0] = 4'd0; odt_dur[3:0] = 4'd1; odt_phase[1:0] = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      odt_req = 2'b00;
      exp_tx = (k == 1 || k == 3) ? 4'b1111 : 4'b0000;
      exp_en = (k == 1 || k == 3);
      n_chk++; if (tx_data[3:0] !== exp_tx) $display("FAIL b2b_tx k=%0d got %b exp %b", k, tx_data[3:0], exp_tx); else n_pass++;
      n_chk++; if (odt_en[0] !== exp_en) $display("FAIL b2b_en k=%0d got %b exp %b", k, odt_en[0], exp_en); else n_pass++;
      n_chk++; if (odt_drop[0] !== 1'b0) $display("FAIL b2b_drop k=%0d got %b exp 0", k, odt_drop[0]); else n_pass++;
      if (k == 2) odt_req = 2'b01;
    end
  endtask

  // Lane 0: 1 -> 5 (4 up moves), then 5 -> 2 (3 down moves), 4 cycles apart.
  task automatic test_tap_steps();
    logic [7:0] tgt;
    logic [7:0] exp_cur;
    logic       up;
    logic       exp_move;
    logic       exp_done;
    logic       exp_busy;
    int         nmv;
    for (int v = 0; v < 2; v++) begin
      tgt     = (v == 0) ? 8'd5 : 8'd2;
      exp_cur = (v == 0) ? 8'd1 : 8'd5;
      nmv     = (v == 0) ? 4 : 3;
      up      = (v == 0);
      tap_target[7:0] = tgt;
      tap_req = 2'b01;
      for (int k = 1; k <= 4*nmv + 3; k++) begin
        tick();
        tap_req = 2'b00;
        exp_move = (k <= 4*nmv - 3) && ((k - 1) % 4 == 0);
        exp_done = (k == 4*nmv + 1);
        exp_busy = (k <= 4*nmv + 1);
        if (exp_move) exp_cur = up ? exp_cur + 8'd1 : exp_cur - 8'd1;
        n_chk++; if (dl_move[0] !== exp_move) $display("FAIL step_move v=%0d k=%0d got %b exp %b", v, k, dl_move[0], exp_move); else n_pass++;
        n_chk++; if (tap_done[0] !== exp_done) $display("FAIL step_done v=%0d k=%0d got %b exp %b", v, k, tap_done[0], exp_done); else n_pass++;
        n_chk++; if (tap_busy[0] !== exp_busy) $display("FAIL step_busy v=%0d k=%0d got %b exp %b", v, k, tap_busy[0], exp_busy); else n_pass++;
        n_chk++; if (cur_tap[7:0] !== exp_cur) $display("FAIL step_cur v=%0d k=%0d got %0d exp %0d", v, k, cur_tap[7:0], exp_cur); else n_pass++;
        if (exp_move) begin
          n_chk++; if (dl_direction[0] !== up) $display("FAIL step_dir v=%0d k=%0d got %b exp %b", v, k, dl_direction[0], up); else n_pass++;
        end
      end
    end
  endtask

  // Lane 0 at tap 2: illegal targets, sticky flag, clear priority, no-op target.
  task automatic test_tap_oor();
    tap_target[7:0] = 8'd200; tap_req = 2'b01;
    tick();
    tap_req = 2'b00;
    n_chk++; if (tap_done[0] !== 1'b1) $display("FAIL oor200_done got %b exp 1", tap_done[0]); else n_pass++;
    n_chk++; if (tap_oor[0] !== 1'b1) $display("FAIL oor200_flag got %b exp 1", tap_oor[0]); else n_pass++;
    n_chk++; if (dl_move[0] !== 1'b0) $display("FAIL oor200_move got %b exp 0", dl_move[0]); else n_pass++;
    n_chk++; if (cur_tap[7:0] !== 8'd2) $display("FAIL oor200_cur got %0d exp 2", cur_tap[7:0]); else n_pass++;
    tick();
    n_chk++; if (tap_done[0] !== 1'b0) $display("FAIL oor200_done2 got %b exp 0", tap_done[0]); else n_pass++;
    n_chk++; if (tap_oor[0] !== 1'b1) $display("FAIL oor_sticky got %b exp 1", tap_oor[0]); else n_pass++;
    tap_target[7:0] = 8'd128; tap_req = 2'b01; tap_clear = 2'b01;
    tick();
    tap_req = 2'b00; tap_clear = 2'b00;
    n_chk++; if (tap_oor[0] !== 1'b1) $display("FAIL oor_set_wins got %b exp 1", tap_oor[0]); else n_pass++;
    n_chk++; if (tap_done[0] !== 1'b1) $display("FAIL oor128_done got %b exp 1", tap_done[0]); else n_pass++;
    n_chk++; if (dl_move[0] !== 1'b0) $display("FAIL oor128_move got %b exp 0", dl_move[0]); else n_pass++;
    tick();
    n_chk++; if (tap_oor[0] !== 1'b1) $display("FAIL oor_hold got %b exp 1", tap_oor[0]); else n_pass++;
    tap_clear = 2'b01;
    tick();
    tap_clear = 2'b00;
    n_chk++; if (tap_oor[0] !== 1'b0) $display("FAIL oor_clear got %b exp 0", tap_oor[0]); else n_pass++;
    tap_target[7:0] = 8'd2; tap_req = 2'b01;
    tick();
    tap_req = 2'b00;
    n_chk++; if (tap_done[0] !== 1'b1) $display("FAIL same_done got %b exp 1", tap_done[0]); else n_pass++;
    n_chk++; if (dl_move[0] !== 1'b0) $display("FAIL same_move got %b exp 0", dl_move[0]); else n_pass++;
    n_chk++; if (tap_oor[0] !== 1'b0) $display("FAIL same_oor got %b exp 0", tap_oor[0]); else n_pass++;
    tick();
  endtask

  // Reset in the middle of a tap move and an ODT pulse aborts both.
  task automatic test_reset_midop();
    tap_target[7:0] = 8'd20; tap_req = 2'b01;
    odt_req = 2'b10; odt_lat[7:4] = 4'd0; odt_dur[7:4] = 4'd8; odt_phase[3:2] = 2'd0;
    tick();
    tap_req = 2'b00; odt_req = 2'b00;
    n_chk++; if (odt_en[1] !== 1'b1) $display("FAIL mid_en_pre got %b exp 1", odt_en[1]); else n_pass++;
    n_chk++; if (dl_move[0] !== 1'b1) $display("FAIL mid_move_pre got %b exp 1", dl_move[0]); else n_pass++;
    tick();
    tick();
    TX_SYNC_RST = 1'b1;
    tick();
    TX_SYNC_RST = 1'b0;
    n_chk++; if (tx_data !== 8'h00) $display("FAIL mid_tx got %h exp 00", tx_data); else n_pass++;
    n_chk++; if (odt_en !== 2'b00) $display("FAIL mid_en got %b exp 00", odt_en); else n_pass++;
    n_chk++; if (cur_tap !== 16'h0101) $display("FAIL mid_cur got %h exp 0101", cur_tap); else n_pass++;
    n_chk++; if (dl_load !== 2'b11) $display("FAIL mid_load got %b exp 11", dl_load); else n_pass++;
    n_chk++; if (tap_busy !== 2'b11) $display("FAIL mid_busy got %b exp 11", tap_busy); else n_pass++;
    for (int k = 5; k <= 8; k++) begin
      tick();
      n_chk++; if (tap_done !== 2'b00) $display("FAIL mid_done k=%0d got %b exp 00", k, tap_done); else n_pass++;
      n_chk++; if (dl_move !== 2'b00) $display("FAIL mid_move k=%0d got %b exp 00", k, dl_move); else n_pass++;
      n_chk++; if (odt_en !== 2'b00) $display("FAIL mid_en_post k=%0d got %b exp 00", k, odt_en); else n_pass++;
      n_chk++; if (tap_busy !== 2'b00) $display("FAIL mid_busy_post k=%0d got %b exp 00", k, tap_busy); else n_pass++;
    end
  endtask

  // Lane 0: 1 -> 10 aborted by dl_out_of_range on the 2nd step; lane 1: 1 -> 3.
  task automatic test_dl_oor();
    logic       exp_mv;
    logic [7:0] exp_cur;
    logic       exp_done0;
    logic       exp_done1;
    logic       exp_oor0;
    tap_target = {8'd3, 8'd10};
    tap_req    = 2'b11;
    for (int k = 1; k <= 11; k++) begin
      tick();
      tap_req = 2'b00;
      dl_out_of_range = (k == 5) ? 2'b01 : 2'b00;
      exp_mv    = (k == 1 || k == 5);
      exp_cur   = (k >= 5) ? 8'd3 : 8'd2;
      exp_done0 = (k == 6);
      exp_done1 = (k == 9);
      exp_oor0  = (k >= 6);
      n_chk++; if (dl_move[0] !== exp_mv) $display("FAIL dloor_move0 k=%0d got %b exp %b", k, dl_move[0], exp_mv); else n_pass++;
      n_chk++; if (dl_move[1] !== exp_mv) $display("FAIL dloor_move1 k=%0d got %b exp %b", k, dl_move[1], exp_mv); else n_pass++;
      n_chk++; if (cur_tap[7:0] !== exp_cur) $display("FAIL dloor_cur0 k=%0d got %0d exp %0d", k, cur_tap[7:0], exp_cur); else n_pass++;
      n_chk++; if (cur_tap[15:8] !== exp_cur) $display("FAIL dloor_cur1 k=%0d got %0d exp %0d", k, cur_tap[15:8], exp_cur); else n_pass++;
      n_chk++; if (tap_done[0] !== exp_done0) $display("FAIL dloor_done0 k=%0d got %b exp %b", k, tap_done[0], exp_done0); else n_pass++;
      n_chk++; if (tap_done[1] !== exp_done1) $display("FAIL dloor_done1 k=%0d got %b exp %b", k, tap_done[1], exp_done1); else n_pass++;
      n_chk++; if (tap_oor[0] !== exp_oor0) $display("FAIL dloor_oor0 k=%0d got %b exp %b", k, tap_oor[0], exp_oor0); else n_pass++;
      n_chk++; if (tap_oor[1] !== 1'b0) $display("FAIL dloor_oor1 k=%0d got %b exp 0", k, tap_oor[1]); else n_pass++;
      if (exp_mv) begin
        n_chk++; if (dl_direction !== 2'b11) $display("FAIL dloor_dir k=%0d got %b exp 11", k, dl_direction); else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    TX_SYNC_RST     = 1'b1;
    odt_req         = 2'b00;
    odt_lat         = 8'h00;
    odt_dur         = 8'h00;
    odt_phase       = 4'h0;
    tap_req         = 2'b00;
    tap_target      = 16'h0101;
    tap_clear       = 2'b00;
    dl_out_of_range = 2'b00;
    test_reset();
    test_odt_basic();
    test_odt_phase();
    test_odt_dur0();
    tick();
    test_back_to_back();
    tick();
    test_tap_steps();
    test_tap_oor();
    test_reset_midop();
    test_dl_oor();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
